// File: rtl/audio_pkg.sv
// Shared types and defaults for the codec audio datapath.
package audio_pkg;

  localparam int unsigned DEF_SAMPLE_W = 16;

  typedef struct packed {
    logic [DEF_SAMPLE_W-1:0] left;
    logic [DEF_SAMPLE_W-1:0] right;
  } stereo_sample_t;

  typedef enum logic [1:0] {
    WAIT_SYNC,
    LOAD,
    SHIFT_L,
    SHIFT_R
  } dac_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous level, with edge detection
// against one history flop behind the synchronised level.
module sync_edge_det #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~hist_q;
  assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/audio_dac_transmitter.sv
// I2S playback transmitter: one-entry hold buffer feeding a per-channel shifter,
// clocked on CLOCK_50 with codec BCLK/DACLRCK synchronised in.
// Build option AUDIO_DAC_HOLD_LAST_EN: repeat the last stereo word on underrun
// instead of muting.
module audio_dac_transmitter
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_W    = DEF_SAMPLE_W,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_DACLRCK,
  input  logic [2*SAMPLE_W-1:0] sample_data,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  AUD_DACDAT,
  output logic                  frame_start,
  output logic                  underrun,
  output logic [CNT_W-1:0]      underrun_cnt
);

  localparam int unsigned BITS_W = $clog2(SAMPLE_W + 1);

  logic bclk_fall, bclk_lvl_unused, bclk_rise_unused;
  logic lrck_lvl, lrck_rise_unused, lrck_fall_unused;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk_i   (CLOCK_50),
    .rst_ni  (reset_n),
    .async_i (AUD_BCLK),
    .level_o (bclk_lvl_unused),
    .rise_o  (bclk_rise_unused),
    .fall_o  (bclk_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_lrck_sync (
    .clk_i   (CLOCK_50),
    .rst_ni  (reset_n),
    .async_i (AUD_DACLRCK),
    .level_o (lrck_lvl),
    .rise_o  (lrck_rise_unused),
    .fall_o  (lrck_fall_unused)
  );

  dac_state_t            state_q;
  logic                  lrck_prev_q;
  logic [2*SAMPLE_W-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [2*SAMPLE_W-1:0] frame_q, frame_d;
  logic [SAMPLE_W-1:0]   shift_q;
  logic [BITS_W-1:0]     bits_q;
  logic                  ready_q, dacdat_q, frame_start_q, underrun_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  accept, load, under;
  logic                  chan_start, left_start, right_start;

  // LRCK is compared with its value at the previous BCLK fall, not with the
  // synchroniser history, so a channel start always lands on a bit boundary.
  assign chan_start  = bclk_fall && (lrck_lvl != lrck_prev_q);
  assign left_start  = chan_start && !lrck_lvl;
  assign right_start = chan_start && lrck_lvl;
  assign accept      = sample_valid && ready_q;

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    frame_d     = frame_q;
    load        = 1'b0;
    under       = 1'b0;
    cnt_d       = cnt_q;
    if (left_start) begin
      load = 1'b1;
      if (hold_full_q) begin
        frame_d     = hold_q;
        hold_full_d = 1'b0;
      end else if (accept) begin
        frame_d = sample_data;
      end else begin
        under = 1'b1;
`ifdef AUDIO_DAC_HOLD_LAST_EN
        frame_d = frame_q;
`else
        frame_d = '0;
`endif
      end
    end else if (accept) begin
      hold_d      = sample_data;
      hold_full_d = 1'b1;
    end
    if (under && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= WAIT_SYNC;
      lrck_prev_q   <= 1'b0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      frame_q       <= '0;
      shift_q       <= '0;
      bits_q        <= '0;
      ready_q       <= 1'b0;
      dacdat_q      <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      cnt_q         <= '0;
    end else begin
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      frame_q       <= frame_d;
      ready_q       <= ~hold_full_d;
      frame_start_q <= load;
      underrun_q    <= under;
      cnt_q         <= cnt_d;
      if (bclk_fall) lrck_prev_q <= lrck_lvl;

      // Channel starts reload the shifter and hold DACDAT for the I2S delay slot.
      if (left_start) begin
        state_q <= LOAD;
        shift_q <= frame_d[2*SAMPLE_W-1:SAMPLE_W];
        bits_q  <= BITS_W'(SAMPLE_W);
      end else if (right_start && (state_q == SHIFT_L || state_q == LOAD)) begin
        state_q <= SHIFT_R;
        shift_q <= frame_q[SAMPLE_W-1:0];
        bits_q  <= BITS_W'(SAMPLE_W);
      end else begin
        if (state_q == LOAD) state_q <= SHIFT_L;
        if (bclk_fall) begin
          if (state_q == WAIT_SYNC || bits_q == '0) begin
            dacdat_q <= 1'b0;
          end else begin
            dacdat_q <= shift_q[SAMPLE_W-1];
            shift_q  <= {shift_q[SAMPLE_W-2:0], 1'b0};
            bits_q   <= bits_q - BITS_W'(1);
          end
        end
      end
    end
  end

  assign sample_ready = ready_q;
  assign AUD_DACDAT   = dacdat_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = cnt_q;

endmodule

// File: doc/audio_dac_transmitter.md
Name: audio_dac_transmitter

Overview:
- I2S transmitter for the codec DAC path, the playback counterpart of the ADC receive path.
- Accepts 32-bit stereo words (left in [31:16], right in [15:0]) from the Nios/FIFO side via a valid/ready handshake and serialises them onto AUD_DACDAT.
- The codec is I2S master: AUD_BCLK and AUD_DACLRCK are inputs, synchronised into the CLOCK_50 domain. The whole block runs on CLOCK_50.

Parameters:
- SAMPLE_W, 16: bits per channel. The input word is 2*SAMPLE_W wide.
- SYNC_STAGES, 2: synchroniser depth for AUD_BCLK and AUD_DACLRCK (minimum 2).
- CNT_W, 16: width of the underrun counter.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset_n  in  1  reset, asynchronous, active-low.
- AUD_BCLK  in  1  codec bit clock (asynchronous).
- AUD_DACLRCK  in  1  codec DAC L/R clock (asynchronous); low = left.
- sample_data  in  2*SAMPLE_W  stereo word; left in MSBs.
- sample_valid  in  1  sample_data is valid.
- sample_ready  out  1  block can accept a word.
- AUD_DACDAT  out  1  serial DAC data.
- frame_start  out  1  one-cycle pulse when a frame is loaded.
- underrun  out  1  one-cycle pulse when a frame is loaded with no data available.
- underrun_cnt  out  CNT_W  saturating count of underruns.

Behaviour:
- Reset values (async assert, sync deassert): AUD_DACDAT=0, sample_ready=0 while reset_n=0, frame_start=0, underrun=0, underrun_cnt=0, hold and shift registers 0, FSM=WAIT_SYNC.
- Synchronisation:
  - AUD_BCLK and AUD_DACLRCK each pass through SYNC_STAGES flops, plus one history flop for edge detect.
  - bclk_fall = synced BCLK transitions 1->0.
  - All serial activity happens only in cycles where bclk_fall=1.
- Timing:
  - AUD_DACDAT updates SYNC_STAGES+1 CLOCK_50 cycles after the physical BCLK falling edge.
  - Requirement: BCLK half-period >= SYNC_STAGES+3 CLOCK_50 cycles (48 kHz x 64 BCLK = 8 cycles, OK).
- Hold register (1 entry):
  - sample_ready = ~hold_full, registered.
  - A word is accepted when valid && ready, and hold_full sets.
- Channel start: a bclk_fall cycle in which synced LRCK differs from the LRCK value latched at the previous bclk_fall.
  - LRCK 1->0 = left start (frame load).
  - LRCK 0->1 = right start.
- Frame load (left start):
  - hold_full=1: frame <= hold, hold_full clears.
  - hold_full=0 and sample_valid=1 in the same cycle: frame <= sample_data (bypass), word counts as accepted, no underrun.
  - Otherwise: frame <= zero, underrun pulses, underrun_cnt += 1, saturating at all-ones.
  - frame_start pulses on every load.
- Shifter, per channel start: shift_reg <= frame half (left on left start, right on right start), bits_left <= SAMPLE_W, AUD_DACDAT held.
  - This is the I2S one-BCLK delay slot.
  - On each following bclk_fall with bits_left>0: AUD_DACDAT <= shift_reg MSB, shift left by one, bits_left -= 1.
  - Once bits_left=0: AUD_DACDAT <= 0 until the next channel start.
  - A channel start arriving before bits_left reaches 0 (short frame) truncates the word and restarts immediately.
- FSM:
  - WAIT_SYNC: AUD_DACDAT=0; right starts ignored; hold may fill. First left start -> LOAD.
  - LOAD: frame load as above (same cycle as the left-start bclk_fall) -> SHIFT_L.
  - SHIFT_L: right start -> SHIFT_R.
  - SHIFT_R: left start -> LOAD.
  - A left start seen in SHIFT_L (missed right edge) -> LOAD; no error flagged.
- Reset mid-frame: output forced to 0 immediately; after release, resynchronise via WAIT_SYNC. The hold content is lost.

Optional Feature:
- Macro: AUDIO_DAC_HOLD_LAST_EN.
- Defined: on underrun, frame keeps its previous value, so the last stereo word repeats. underrun and underrun_cnt still update.
- Undefined: on underrun, frame <= 0 (mute).

Decomposition:
- Package audio_pkg:
  - SAMPLE_W default constant.
  - typedef stereo_sample_t, a packed struct {left, right} of SAMPLE_W each.
  - enum dac_state_t {WAIT_SYNC, LOAD, SHIFT_L, SHIFT_R}.
- Sub-module sync_edge_det (params STAGES; outputs level, rise, fall). Two instances: BCLK and DACLRCK.

Test Plan:
- Reset, then 64-BCLK frames with one word 0xA5C3_0F0F preloaded.
  - After the first LRCK fall: delay slot, then bits 1010010111000011 (MSB first).
  - After the LRCK rise: 0000111100001111.
  - Remaining bits of each half are 0; frame_start pulses once.
- Underrun: no words supplied for 3 frames.
  - 3 underrun pulses, underrun_cnt=3.
  - Output all zeros; with HOLD_LAST_EN, the previous word repeats 3 times.
- Handshake backpressure: hold valid high continuously with incrementing data.
  - Exactly one word accepted per frame.
  - sample_ready low between acceptance and the next left start.
  - No word dropped or duplicated.
- Bypass: hold empty, valid asserted in the exact left-start cycle with 0x8001_7FFE.
  - Transmitted in that frame; no underrun.
- Reset asserted mid-left-word.
  - AUD_DACDAT=0 asynchronously.
  - After release, right-channel edges ignored until the next LRCK fall.
  - Then normal output resumes.
- underrun_cnt saturation (CNT_W=4 override): 20 underruns -> counter holds at 15.
